traffic_controller: RTL and testbench
=====================================

TRAFFIC_CONTROLLER -- requirements
Module: traffic_controller

Interface
REQ-001 SHALL have parameter NUM_DIRS, default 2, meaning number of approach directions (2..8).
REQ-002 SHALL have parameter TIMER_W, default 7, meaning phase-timer width in bits.
REQ-003 SHALL have parameter GREEN_TIME, default 20, meaning minimum green duration in ticks (1..2^TIMER_W-1).
REQ-004 SHALL have parameter YELLOW_TIME, default 3, meaning yellow duration in ticks (1..2^TIMER_W-1).
REQ-005 SHALL have parameter ALLRED_TIME, default 1, meaning all-red clearance duration in ticks (1..2^TIMER_W-1).
REQ-006 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port enable  input  1  intersection enable; low forces all directions red.
REQ-009 SHALL have port tick  input  1  one-cycle timebase strobe (nominally 1 s).
REQ-010 SHALL have port demand  input  NUM_DIRS  per-direction vehicle/pedestrian request, level-sensitive.
REQ-011 SHALL have port green_light  output  NUM_DIRS  per-direction green lamp.
REQ-012 SHALL have port yellow_light  output  NUM_DIRS  per-direction yellow lamp.
REQ-013 SHALL have port red_light  output  NUM_DIRS  per-direction red lamp.
REQ-014 SHALL have port active_dir  output  $clog2(NUM_DIRS)  index of direction owning the current phase.
REQ-015 SHALL have port phase_timer  output  TIMER_W  remaining ticks in current phase.

Function
REQ-016 SHALL implement states DISABLED, GREEN, YELLOW, ALLRED.
REQ-017 SHALL, on entering a state, load phase_timer with GREEN_TIME, YELLOW_TIME or ALLRED_TIME respectively; DISABLED holds 0.
REQ-018 SHALL decrement phase_timer by 1 on each cycle where tick=1 and phase_timer>1; phase therefore lasts exactly its parameter in ticks.
REQ-019 SHALL, on tick=1 with phase_timer==1, transition at that clock edge: GREEN->YELLOW, YELLOW->ALLRED, ALLRED->GREEN.
REQ-020 SHALL, on GREEN expiry with no demand from any other direction, stay in GREEN for the same direction and reload GREEN_TIME (green extension).
REQ-021 SHALL, on ALLRED->GREEN, select the next active_dir round-robin starting at active_dir+1 (wrap NUM_DIRS-1->0) among directions with demand=1; if none, active_dir+1.
REQ-022 SHALL drive, for active_dir: GREEN state green=1, YELLOW state yellow=1, otherwise red=1; every non-active direction red=1.
REQ-023 SHALL guarantee exactly one of green/yellow/red is 1 per direction every cycle, and at most one direction non-red.
REQ-024 SHALL, when enable=0, enter DISABLED at the next edge from any state, all red, phase_timer=0, active_dir unchanged.
REQ-025 SHALL, when enable rises in DISABLED, enter ALLRED (ALLRED_TIME) before any green; next direction chosen per REQ-021.
REQ-026 SHALL give enable=0 priority over a simultaneous tick expiry.
REQ-027 SHALL ignore tick in DISABLED; tick held high for consecutive cycles counts once per cycle.
REQ-028 SHALL register all outputs; lamp outputs change on the same edge as the state change (no extra latency).

Reset
REQ-029 SHALL, on reset=1 at a clock edge, set state DISABLED, active_dir=NUM_DIRS-1, phase_timer=0, all red_light=1, green/yellow=0.
REQ-030 SHALL give reset priority over enable, tick and demand; reset mid-phase aborts immediately.
REQ-031 SHALL, after reset releases with enable=1, take ALLRED then first green at direction 0 (absent other demand).

Structure
REQ-032 SHALL place the state enum and default duration constants in shared package traffic_pkg.
REQ-033 SHALL implement next-direction selection as sub-module tl_rr_select (inputs demand, current index; output next index).

Verification
REQ-034 SHALL cover: NUM_DIRS=2, defaults, enable=1, demand=2'b11, tick every cycle -> dir0 green 20 ticks, yellow 3, allred 1, dir1 green.
REQ-035 SHALL cover: demand=2'b01 only during dir0 green -> green extends by 20 ticks repeatedly, no yellow.
REQ-036 SHALL cover: NUM_DIRS=4, demand=4'b1001 from dir0 -> sequence dir0 -> dir3 -> dir0, dirs 1,2 skipped.
REQ-037 SHALL cover: enable dropped at phase_timer=2 in YELLOW -> next edge all red, timer 0; re-enable -> ALLRED 1 tick then green.
REQ-038 SHALL cover: reset asserted during GREEN with simultaneous tick expiry -> reset values per REQ-029, no yellow emitted.
REQ-039 SHALL check REQ-023 invariants as assertions on every cycle of all scenarios.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and default phase durations for the intersection controller.
package traffic_pkg;

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_GREEN    = 2'd1,
      ST_YELLOW   = 2'd2,
      ST_ALLRED   = 2'd3
   } tl_state_t;

   localparam int DEF_NUM_DIRS    = 2;
   localparam int DEF_TIMER_W     = 7;
   localparam int DEF_GREEN_TIME  = 20;
   localparam int DEF_YELLOW_TIME = 3;
   localparam int DEF_ALLRED_TIME = 1;

endpackage

// File: rtl/tl_rr_select.sv
// Round-robin next-direction picker: first requesting direction after current,
// wrapping; falls back to current+1 when nobody is requesting.
module tl_rr_select #(
   parameter  int NUM_DIRS = 2,
   localparam int DIR_W    = $clog2(NUM_DIRS)
) (
   input  logic [NUM_DIRS-1:0] demand,
   input  logic [DIR_W-1:0]    current,
   output logic [DIR_W-1:0]    next
);

   int                  idx;
   logic [NUM_DIRS-1:0] shifted;

   // Scan from farthest to nearest so the nearest requester overwrites last;
   // the current direction itself is the lowest-priority candidate.
   always_comb begin
      idx     = 0;
      shifted = '0;
      next    = DIR_W'((int'(current) + 1) % NUM_DIRS);
      for (int i = NUM_DIRS; i >= 1; i--) begin
         idx     = (int'(current) + i) % NUM_DIRS;
         shifted = demand >> idx;
         if (shifted[0]) next = DIR_W'(idx);
      end
   end

endmodule

// File: rtl/traffic_controller.sv
// Multi-direction traffic light sequencer: green/yellow/all-red phases timed in
// ticks, green extension when idle, round-robin hand-over among requesters.
module traffic_controller
   import traffic_pkg::*;
#(
   parameter  int NUM_DIRS    = DEF_NUM_DIRS,
   parameter  int TIMER_W     = DEF_TIMER_W,
   parameter  int GREEN_TIME  = DEF_GREEN_TIME,
   parameter  int YELLOW_TIME = DEF_YELLOW_TIME,
   parameter  int ALLRED_TIME = DEF_ALLRED_TIME,
   localparam int DIR_W       = $clog2(NUM_DIRS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                tick,
   input  logic [NUM_DIRS-1:0] demand,
   output logic [NUM_DIRS-1:0] green_light,
   output logic [NUM_DIRS-1:0] yellow_light,
   output logic [NUM_DIRS-1:0] red_light,
   output logic [DIR_W-1:0]    active_dir,
   output logic [TIMER_W-1:0]  phase_timer,
   output tl_state_t           state
);

   localparam logic [TIMER_W-1:0] T_GREEN  = TIMER_W'(GREEN_TIME);
   localparam logic [TIMER_W-1:0] T_YELLOW = TIMER_W'(YELLOW_TIME);
   localparam logic [TIMER_W-1:0] T_ALLRED = TIMER_W'(ALLRED_TIME);
   localparam logic [TIMER_W-1:0] T_ONE    = TIMER_W'(1);

   tl_state_t           state_d;
   logic [DIR_W-1:0]    dir_d;
   logic [DIR_W-1:0]    rr_next;
   logic [TIMER_W-1:0]  timer_d;
   logic [NUM_DIRS-1:0] own_now;
   logic [NUM_DIRS-1:0] own_d;
   logic [NUM_DIRS-1:0] green_d;
   logic [NUM_DIRS-1:0] yellow_d;
   logic [NUM_DIRS-1:0] red_d;
   logic                other_demand;

   tl_rr_select #(.NUM_DIRS(NUM_DIRS)) u_rr (
      .demand  (demand),
      .current (active_dir),
      .next    (rr_next)
   );

   assign own_now      = NUM_DIRS'(1) << active_dir;
   assign other_demand = |(demand & ~own_now);

   always_comb begin
      state_d = state;
      dir_d   = active_dir;
      timer_d = phase_timer;
      if (!enable) begin
         state_d = ST_DISABLED;
         timer_d = '0;
      end else if (state == ST_DISABLED) begin
         state_d = ST_ALLRED;
         timer_d = T_ALLRED;
      end else if (tick) begin
         if (phase_timer > T_ONE) begin
            timer_d = phase_timer - T_ONE;
         end else begin
            case (state)
               ST_GREEN: begin
                  // Nobody else waiting: keep the green and restart its timer.
                  if (other_demand) begin
                     state_d = ST_YELLOW;
                     timer_d = T_YELLOW;
                  end else begin
                     timer_d = T_GREEN;
                  end
               end
               ST_YELLOW: begin
                  state_d = ST_ALLRED;
                  timer_d = T_ALLRED;
               end
               ST_ALLRED: begin
                  state_d = ST_GREEN;
                  dir_d   = rr_next;
                  timer_d = T_GREEN;
               end
               default: ;
            endcase
         end
      end

      // Lamps are derived from the next state so they switch on the same edge.
      own_d    = NUM_DIRS'(1) << dir_d;
      green_d  = '0;
      yellow_d = '0;
      red_d    = '1;
      if (state_d == ST_GREEN) begin
         green_d = own_d;
         red_d   = ~own_d;
      end else if (state_d == ST_YELLOW) begin
         yellow_d = own_d;
         red_d    = ~own_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_DISABLED;
         active_dir   <= DIR_W'(NUM_DIRS - 1);
         phase_timer  <= '0;
         green_light  <= '0;
         yellow_light <= '0;
         red_light    <= '1;
      end else begin
         state        <= state_d;
         active_dir   <= dir_d;
         phase_timer  <= timer_d;
         green_light  <= green_d;
         yellow_light <= yellow_d;
         red_light    <= red_d;
      end
   end

endmodule

// File: tb/tb_traffic_controller.sv
// Bench for traffic_controller: a 2-direction default instance and a
// 4-direction short-timing instance run side by side against a phase model.
module tb_traffic_controller;
   import traffic_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       enable;
   logic       tick;
   logic [1:0] demand2;
   logic [3:0] demand4;

   logic [1:0] g2, y2, r2;
   logic [0:0] dir2;
   logic [6:0] tmr2;
   tl_state_t  st2;
   logic [3:0] g4, y4, r4;
   logic [1:0] dir4;
   logic [6:0] tmr4;
   tl_state_t  st4;

   int total = 0;
   int bad   = 0;
   bit mon_on = 1'b0;

   traffic_controller #(.NUM_DIRS(2)) dut2 (
      .clk(clk), .reset(reset), .enable(enable), .tick(tick), .demand(demand2),
      .green_light(g2), .yellow_light(y2), .red_light(r2),
      .active_dir(dir2), .phase_timer(tmr2), .state(st2)
   );

   traffic_controller #(
      .NUM_DIRS(4), .TIMER_W(7), .GREEN_TIME(5), .YELLOW_TIME(2), .ALLRED_TIME(2)
   ) dut4 (
      .clk(clk), .reset(reset), .enable(enable), .tick(tick), .demand(demand4),
      .green_light(g4), .yellow_light(y4), .red_light(r4),
      .active_dir(dir4), .phase_timer(tmr4), .state(st4)
   );

   // Reference model: phase names, owner and ticks left, per instance.
   localparam int P_OFF = 0, P_GO = 1, P_CAUTION = 2, P_CLEAR = 3;
   int m_n  [2] = '{2, 4};
   int m_gt [2] = '{20, 5};
   int m_yt [2] = '{3, 2};
   int m_at [2] = '{1, 2};
   int m_phase [2];
   int m_dir   [2];
   int m_tmr   [2];

   function automatic void model_step(int k, bit rst, bit en, bit tk, int dm);
      int n, others, nd;
      bit found;
      n = m_n[k];
      if (rst) begin
         m_phase[k] = P_OFF; m_dir[k] = n - 1; m_tmr[k] = 0;
      end else if (!en) begin
         m_phase[k] = P_OFF; m_tmr[k] = 0;
      end else if (m_phase[k] == P_OFF) begin
         m_phase[k] = P_CLEAR; m_tmr[k] = m_at[k];
      end else if (tk) begin
         if (m_tmr[k] > 1) begin
            m_tmr[k] = m_tmr[k] - 1;
         end else if (m_phase[k] == P_GO) begin
            others = dm & ~(1 << m_dir[k]);
            if (others != 0) begin
               m_phase[k] = P_CAUTION; m_tmr[k] = m_yt[k];
            end else begin
               m_tmr[k] = m_gt[k];
            end
         end else if (m_phase[k] == P_CAUTION) begin
            m_phase[k] = P_CLEAR; m_tmr[k] = m_at[k];
         end else begin
            found = 1'b0;
            nd = (m_dir[k] + 1) % n;
            for (int s = 1; s <= n; s++) begin
               if (!found && (((dm >> ((m_dir[k] + s) % n)) & 1) == 1)) begin
                  nd = (m_dir[k] + s) % n;
                  found = 1'b1;
               end
            end
            m_phase[k] = P_GO; m_dir[k] = nd; m_tmr[k] = m_gt[k];
         end
      end
   endfunction

   function automatic logic [31:0] exp_obs(int k);
      int g, y, r, stc;
      g = (m_phase[k] == P_GO) ? (1 << m_dir[k]) : 0;
      y = (m_phase[k] == P_CAUTION) ? (1 << m_dir[k]) : 0;
      r = ((1 << m_n[k]) - 1) & ~(g | y);
      case (m_phase[k])
         P_GO:      stc = int'(ST_GREEN);
         P_CAUTION: stc = int'(ST_YELLOW);
         P_CLEAR:   stc = int'(ST_ALLRED);
         default:   stc = int'(ST_DISABLED);
      endcase
      return 32'((g << 19) | (y << 15) | (r << 11) | (m_dir[k] << 9) | (m_tmr[k] << 2) | stc);
   endfunction

   function automatic logic [31:0] obs_dut(int k);
      if (k == 0)
         return {9'd0, 2'b00, g2, 2'b00, y2, 2'b00, r2, 1'b0, dir2, tmr2, st2};
      return {9'd0, g4, y4, r4, dir4, tmr4, st4};
   endfunction

   task automatic drive(input bit rst, input bit en, input bit tk,
                        input logic [1:0] d2, input logic [3:0] d4);
      reset = rst; enable = en; tick = tk; demand2 = d2; demand4 = d4;
      @(posedge clk);
      model_step(0, rst, en, tk, int'(d2));
      model_step(1, rst, en, tk, int'(d4));
      @(negedge clk);
   endtask

   // Lamp sanity on every cycle: one lamp per direction, at most one non-red.
   always @(negedge clk) begin
      if (mon_on) begin
         total++;
         if (!((((g2 & y2) | (g2 & r2) | (y2 & r2)) === 2'b00) &&
               ((g2 | y2 | r2) === 2'b11) && ($countones(~r2) <= 1))) begin
            bad++;
            $display("FAIL lamp_invariant2 got g=%b y=%b r=%b want one-hot lamps, <=1 non-red", g2, y2, r2);
         end
         total++;
         if (!((((g4 & y4) | (g4 & r4) | (y4 & r4)) === 4'b0000) &&
               ((g4 | y4 | r4) === 4'b1111) && ($countones(~r4) <= 1))) begin
            bad++;
            $display("FAIL lamp_invariant4 got g=%b y=%b r=%b want one-hot lamps, <=1 non-red", g4, y4, r4);
         end
      end
   end

   task automatic test_reset();
      drive(1'b1, 1'b0, 1'b0, 2'b00, 4'b0000);
      mon_on = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 2'b11, 4'b1111);
      total++;
      if ({g2, y2, r2, dir2, tmr2} !== {2'b00, 2'b00, 2'b11, 1'b1, 7'd0} || st2 !== ST_DISABLED) begin
         bad++;
         $display("FAIL reset2 got g=%b y=%b r=%b dir=%0d tmr=%0d st=%0d want 00/00/11 dir=1 tmr=0 st=0",
                  g2, y2, r2, dir2, tmr2, st2);
      end
      total++;
      if ({g4, y4, r4, dir4, tmr4} !== {4'h0, 4'h0, 4'hF, 2'd3, 7'd0} || st4 !== ST_DISABLED) begin
         bad++;
         $display("FAIL reset4 got g=%b y=%b r=%b dir=%0d tmr=%0d want 0/0/F dir=3 tmr=0",
                  g4, y4, r4, dir4, tmr4);
      end
   endtask

   task automatic test_cycle();
      int cg, cy, ca;
      cg = 0; cy = 0; ca = 0;
      drive(1'b1, 1'b0, 1'b0, 2'b00, 4'b0000);
      for (int c = 0; c <= 25; c++) begin
         drive(1'b0, 1'b1, 1'b1, 2'b11, 4'b0000);
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_dut(k) !== exp_obs(k)) begin
               bad++;
               $display("FAIL cycle_model[%0d] c=%0d got=%h want=%h", k, c, obs_dut(k), exp_obs(k));
            end
         end
         if (c < 25) begin
            if (g2 === 2'b01) cg++;
            if (y2 === 2'b01) cy++;
            if (st2 === ST_ALLRED) ca++;
         end
      end
      total++;
      if (cg != 20 || cy != 3 || ca != 2 || g2 !== 2'b10) begin
         bad++;
         $display("FAIL cycle_durations got green0=%0d yellow0=%0d allred=%0d g=%b want 20/3/2 g=10",
                  cg, cy, ca, g2);
      end
   endtask

   task automatic test_extension();
      int cg, cy;
      cg = 0; cy = 0;
      drive(1'b1, 1'b0, 1'b0, 2'b00, 4'b0000);
      for (int c = 0; c < 80; c++) begin
         drive(1'b0, 1'b1, 1'b1, 2'b01, 4'b0000);
         total++;
         if (obs_dut(0) !== exp_obs(0)) begin
            bad++;
            $display("FAIL extend_model c=%0d got=%h want=%h", c, obs_dut(0), exp_obs(0));
         end
         if (g2 === 2'b01) cg++;
         if (y2 !== 2'b00) cy++;
         if (c == 21) begin
            total++;
            if (tmr2 !== 7'd20) begin
               bad++;
               $display("FAIL extend_reload got tmr=%0d want 20", tmr2);
            end
         end
      end
      total++;
      if (cg != 79 || cy != 0) begin
         bad++;
         $display("FAIL extend_counts got green0=%0d yellow=%0d want 79/0", cg, cy);
      end
   endtask

   task automatic test_skip();
      int seq[$];
      logic [3:0] prev;
      bit skipped_bad;
      prev = 4'h0; skipped_bad = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 2'b00, 4'b0000);
      for (int c = 0; c < 40; c++) begin
         drive(1'b0, 1'b1, 1'b1, 2'b00, 4'b1001);
         total++;
         if (obs_dut(1) !== exp_obs(1)) begin
            bad++;
            $display("FAIL skip_model c=%0d got=%h want=%h", c, obs_dut(1), exp_obs(1));
         end
         if (g4 !== 4'h0 && g4 !== prev) seq.push_back(int'(dir4));
         if (g4[1] !== 1'b0 || g4[2] !== 1'b0) skipped_bad = 1'b1;
         prev = g4;
      end
      total++;
      if (seq.size() < 3 || seq[0] != 0 || seq[1] != 3 || seq[2] != 0 || skipped_bad) begin
         bad++;
         $display("FAIL skip_order got n=%0d first=%0d,%0d,%0d dirs12_green=%0d want 0,3,0 none",
                  seq.size(), (seq.size() > 0) ? seq[0] : -1, (seq.size() > 1) ? seq[1] : -1,
                  (seq.size() > 2) ? seq[2] : -1, skipped_bad);
      end
   endtask

   task automatic test_enable_drop();
      bit found;
      found = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 2'b00, 4'b0000);
      for (int c = 0; c < 100 && !found; c++) begin
         drive(1'b0, 1'b1, 1'b1, 2'b11, 4'b0011);
         if (st2 === ST_YELLOW && tmr2 === 7'd2) found = 1'b1;
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL drop_reach got no yellow with tmr=2 want reached within 100 cycles");
      end
      drive(1'b0, 1'b0, 1'b1, 2'b11, 4'b0011);
      total++;
      if ({g2, y2, r2, dir2, tmr2} !== {2'b00, 2'b00, 2'b11, 1'b0, 7'd0} || st2 !== ST_DISABLED) begin
         bad++;
         $display("FAIL drop_disabled got g=%b y=%b r=%b dir=%0d tmr=%0d st=%0d want all red dir=0 tmr=0",
                  g2, y2, r2, dir2, tmr2, st2);
      end
      for (int c = 0; c < 3; c++) drive(1'b0, 1'b0, 1'b1, 2'b11, 4'b0011);
      total++;
      if (obs_dut(0) !== exp_obs(0) || tmr2 !== 7'd0) begin
         bad++;
         $display("FAIL drop_hold got=%h want=%h", obs_dut(0), exp_obs(0));
      end
      drive(1'b0, 1'b1, 1'b1, 2'b11, 4'b0011);
      total++;
      if (st2 !== ST_ALLRED || tmr2 !== 7'd1 || r2 !== 2'b11) begin
         bad++;
         $display("FAIL reenable_allred got st=%0d tmr=%0d r=%b want st=3 tmr=1 r=11", st2, tmr2, r2);
      end
      drive(1'b0, 1'b1, 1'b1, 2'b11, 4'b0011);
      total++;
      if (g2 !== 2'b10 || tmr2 !== 7'd20 || obs_dut(1) !== exp_obs(1)) begin
         bad++;
         $display("FAIL reenable_green got g=%b tmr=%0d dut4=%h want g=10 tmr=20 dut4=%h",
                  g2, tmr2, obs_dut(1), exp_obs(1));
      end
   endtask

   task automatic test_reset_mid();
      bit found;
      found = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 2'b00, 4'b0000);
      for (int c = 0; c < 100 && !found; c++) begin
         drive(1'b0, 1'b1, 1'b1, 2'b11, 4'b1111);
         if (st2 === ST_GREEN && tmr2 === 7'd1) found = 1'b1;
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL midreset_reach got no green with tmr=1 want reached within 100 cycles");
      end
      drive(1'b1, 1'b1, 1'b1, 2'b11, 4'b1111);
      total++;
      if ({g2, y2, r2, dir2, tmr2} !== {2'b00, 2'b00, 2'b11, 1'b1, 7'd0} || st2 !== ST_DISABLED) begin
         bad++;
         $display("FAIL midreset got g=%b y=%b r=%b dir=%0d tmr=%0d st=%0d want 00/00/11 dir=1 tmr=0 st=0",
                  g2, y2, r2, dir2, tmr2, st2);
      end
      drive(1'b0, 1'b1, 1'b1, 2'b11, 4'b1111);
      total++;
      if (y2 !== 2'b00 || st2 !== ST_ALLRED) begin
         bad++;
         $display("FAIL midreset_after got y=%b st=%0d want y=00 st=3", y2, st2);
      end
   endtask

   task automatic test_random();
      bit rst, en, tk;
      drive(1'b1, 1'b0, 1'b0, 2'b00, 4'b0000);
      for (int c = 0; c < 1500; c++) begin
         rst = ($urandom_range(0, 79) == 0);
         en  = ($urandom_range(0, 19) != 0);
         tk  = ($urandom_range(0, 1) == 1);
         drive(rst, en, tk, 2'($urandom), 4'($urandom));
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_dut(k) !== exp_obs(k)) begin
               bad++;
               $display("FAIL random_model[%0d] c=%0d got=%h want=%h", k, c, obs_dut(k), exp_obs(k));
            end
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want bench completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_cycle();
      test_extension();
      test_skip();
      test_enable_drop();
      test_reset_mid();
      test_random();
      mon_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
